// File: rtl/hdlc_bit_destuffer.sv
// HDLC receive de-framer: flag hunt, zero-bit destuffing and payload packing.
// Raw line bits arrive IN_W at a time (MSB first) and are consumed one per cycle.
// Payload leaves as OUT_W-bit left-aligned words; the last word of a frame has out_last set.
// Optional feature macro: HDLC_ABORT_DETECT_EN (adds out_err and an abort-terminating word).
module hdlc_bit_destuffer #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(OUT_W+1)-1:0] out_nbits,
  output logic                       out_last,
`ifdef HDLC_ABORT_DETECT_EN
  output logic                       out_err,
`endif
  output logic                       frame_active
);

  localparam int NW = $clog2(OUT_W + 1);
  localparam int SW = $clog2(IN_W + 1);
  localparam logic [NW-1:0] FULL_N = NW'(OUT_W);
  localparam logic [SW-1:0] IN_N   = SW'(IN_W);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // registered state
  logic [1:0]       state;
  logic [2:0]       ones_cnt;
  logic [7:0]       raw8;
  logic [6:0]       dl;        // delay line, newest bit in dl[0]
  logic [2:0]       dl_n;
  logic [OUT_W-1:0] acc;       // accumulator, newest bit in acc[0]
  logic [NW-1:0]    acc_n;
  logic             pend_last; // a frame-terminating word still has to be emitted
  logic [IN_W-1:0]  sr;
  logic [SW-1:0]    sr_n;

  // next-state values
  logic [1:0]       state_d;
  logic [2:0]       ones_d;
  logic [7:0]       raw8_d;
  logic [6:0]       dl_d;
  logic [2:0]       dl_n_d;
  logic [OUT_W-1:0] acc_d;
  logic [NW-1:0]    acc_n_d;
  logic             pend_last_d;
  logic [IN_W-1:0]  sr_d;
  logic [SW-1:0]    sr_n_d;
  logic             out_valid_d;
  logic [OUT_W-1:0] out_data_d;
  logic [NW-1:0]    out_nbits_d;
  logic             out_last_d;
`ifdef HDLC_ABORT_DETECT_EN
  logic             pend_err;
  logic             pend_err_d;
  logic             out_err_d;
`endif

  // per-bit decode
  logic       out_free;
  logic       acc_full;
  logic       stall;
  logic       step;
  logic       bit_in;
  logic [2:0] ones_nx;
  logic [7:0] raw8_nx;
  logic       is_abort;
  logic       is_flag;
  logic       is_stuff;

  // Decode of the raw bit at the head of the shift register and the flow-control handshake.
  always_comb begin
    out_free = !out_valid || out_ready;
    acc_full = (acc_n == FULL_N);
    stall    = !out_free && (acc_full || pend_last);
    step     = (sr_n != '0) && !stall;
    in_ready = (sr_n == '0) || ((sr_n == SW'(1)) && step);
    bit_in   = sr[IN_W-1];
    ones_nx  = bit_in ? ((ones_cnt == 3'd7) ? 3'd7 : ones_cnt + 3'd1) : 3'd0;
    raw8_nx  = {raw8[6:0], bit_in};
    is_abort = (ones_nx == 3'd7);
    is_flag  = (raw8_nx == 8'h7E);
    is_stuff = !bit_in && (ones_cnt == 3'd5);
  end

  // Next-state logic: output register load, input shift register, then the bit engine.
  always_comb begin
    state_d     = state;
    ones_d      = ones_cnt;
    raw8_d      = raw8;
    dl_d        = dl;
    dl_n_d      = dl_n;
    acc_d       = acc;
    acc_n_d     = acc_n;
    pend_last_d = pend_last;
    sr_d        = sr;
    sr_n_d      = sr_n;
    out_valid_d = out_valid && !out_ready;
    out_data_d  = out_data;
    out_nbits_d = out_nbits;
    out_last_d  = out_last;
`ifdef HDLC_ABORT_DETECT_EN
    pend_err_d  = pend_err;
    out_err_d   = out_err;
`endif

    // A full word always leaves before a pending terminator, so a flag that
    // coincides with a full accumulator yields the full word first.
    if (out_free) begin
      if (acc_full) begin
        out_valid_d = 1'b1;
        out_data_d  = acc;
        out_nbits_d = FULL_N;
        out_last_d  = 1'b0;
`ifdef HDLC_ABORT_DETECT_EN
        out_err_d   = 1'b0;
`endif
        acc_d       = '0;
        acc_n_d     = '0;
      end else if (pend_last) begin
        out_valid_d = 1'b1;
        out_data_d  = acc << (FULL_N - acc_n);
        out_nbits_d = acc_n;
        out_last_d  = 1'b1;
`ifdef HDLC_ABORT_DETECT_EN
        out_err_d   = pend_err;
        pend_err_d  = 1'b0;
`endif
        acc_d       = '0;
        acc_n_d     = '0;
        pend_last_d = 1'b0;
      end
    end

    if (step) begin
      sr_d   = sr << 1;
      sr_n_d = sr_n - 1'b1;
    end
    if (in_valid && in_ready) begin
      sr_d   = in_data;
      sr_n_d = IN_N;
    end

    // DATA is entered only when the first payload bit leaves the delay line, so a
    // run of back-to-back flags never raises frame_active nor emits a word.
    if (step) begin
      ones_d = ones_nx;
      raw8_d = raw8_nx;
      if (is_abort) begin
`ifdef HDLC_ABORT_DETECT_EN
        if (state == ST_DATA) begin
          pend_last_d = 1'b1;
          pend_err_d  = 1'b1;
        end
`endif
        state_d = ST_HUNT;
        dl_d    = '0;
        dl_n_d  = '0;
        acc_d   = '0;
        acc_n_d = '0;
      end else if (is_flag) begin
        if (state == ST_DATA) pend_last_d = 1'b1;
        state_d = ST_SYNC;
        dl_d    = '0;
        dl_n_d  = '0;
      end else if ((state != ST_HUNT) && !is_stuff) begin
        dl_d = {dl[5:0], bit_in};
        if (dl_n == 3'd7) begin
          acc_d   = {acc_d[OUT_W-2:0], dl[6]};
          acc_n_d = acc_n_d + 1'b1;
          state_d = ST_DATA;
        end else begin
          dl_n_d = dl_n + 3'd1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      ones_cnt  <= '0;
      raw8      <= '0;
      dl        <= '0;
      dl_n      <= '0;
      acc       <= '0;
      acc_n     <= '0;
      pend_last <= 1'b0;
      sr        <= '0;
      sr_n      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
`ifdef HDLC_ABORT_DETECT_EN
      pend_err  <= 1'b0;
      out_err   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      ones_cnt  <= ones_d;
      raw8      <= raw8_d;
      dl        <= dl_d;
      dl_n      <= dl_n_d;
      acc       <= acc_d;
      acc_n     <= acc_n_d;
      pend_last <= pend_last_d;
      sr        <= sr_d;
      sr_n      <= sr_n_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_nbits <= out_nbits_d;
      out_last  <= out_last_d;
`ifdef HDLC_ABORT_DETECT_EN
      pend_err  <= pend_err_d;
      out_err   <= out_err_d;
`endif
    end
  end

  assign frame_active = (state == ST_DATA);

endmodule

// File: tb/tb_hdlc_bit_destuffer.sv
// Bench for hdlc_bit_destuffer (IN_W=16, OUT_W=8): frame-level reference model + scoreboard.
module tb_hdlc_bit_destuffer;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int NW    = $clog2(OUT_W + 1);
`ifdef HDLC_ABORT_DETECT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [NW-1:0]    out_nbits;
  logic             out_last;
  logic             frame_active;
`ifdef HDLC_ABORT_DETECT_EN
  logic             out_err;
`endif

  always #5 clk = ~clk;

  hdlc_bit_destuffer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nbits(out_nbits), .out_last(out_last),
`ifdef HDLC_ABORT_DETECT_EN
    .out_err(out_err),
`endif
    .frame_active(frame_active)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fa_cnt = 0;
  int ir_cnt = 0;
  int stuff_run = 0;
  bit bits[$];
  int expq[$];
  int pinq[$];

  // word encoding: data[7:0] | nbits<<8 | last<<12 | err<<13
  function automatic int enc(int data, int nb, int last, int err);
    return (data & 'hFF) | (nb << 8) | (last << 12) | (err << 13);
  endfunction

  function automatic int dut_word();
    int e;
    e = 0;
`ifdef HDLC_ABORT_DETECT_EN
    e = int'(out_err);
`endif
    return enc(int'(out_data), int'(out_nbits), int'(out_last), e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // raw line bits, no stuffing
  task automatic push_v(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    stuff_run = 0;
  endtask

  // payload bits with transmitter-side zero insertion after five ones
  task automatic push_pay(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bits.push_back(v[i]);
      if (v[i]) begin
        stuff_run++;
        if (stuff_run == 5) begin
          bits.push_back(1'b0);
          stuff_run = 0;
        end
      end else begin
        stuff_run = 0;
      end
    end
  endtask

  task automatic destuff(input bit s[$], output bit d[$]);
    int run;
    run = 0;
    d.delete();
    foreach (s[i]) begin
      if (!s[i] && run == 5) run = 0;
      else begin
        d.push_back(s[i]);
        run = s[i] ? run + 1 : 0;
      end
    end
  endtask

  task automatic emit(input bit d[$], input int n, input bit last, input bit err);
    int w, r, v;
    w = n / OUT_W;
    for (int k = 0; k < w; k++) begin
      v = 0;
      for (int j = 0; j < OUT_W; j++) v = (v << 1) | int'(d[k*OUT_W+j]);
      expq.push_back(enc(v, OUT_W, 0, 0));
    end
    if (last) begin
      if (err) expq.push_back(enc(0, 0, 1, 1));
      else begin
        r = n % OUT_W;
        v = 0;
        for (int j = 0; j < r; j++) v = (v << 1) | int'(d[w*OUT_W+j]);
        expq.push_back(enc(v << (OUT_W - r), r, 1, 0));
      end
    end
  endtask

  // Frame-level reference: split the raw stream at flags and abort runs,
  // destuff each segment and chop it into words.
  task automatic model_run();
    int ones;
    bit [7:0] h;
    bit synced;
    bit b;
    bit seg[$];
    bit d[$];
    ones = 0; h = '0; synced = 0;
    foreach (bits[i]) begin
      b = bits[i];
      h = {h[6:0], b};
      ones = b ? ((ones == 7) ? 7 : ones + 1) : 0;
      if (ones == 7) begin
        if (synced) begin
          destuff(seg, d);
          if (d.size() > 7) emit(d, d.size() - 7, ABORT_EN, 1'b1);
        end
        synced = 0;
        seg.delete();
      end else if (h == 8'h7E) begin
        if (synced) begin
          for (int k = 0; k < 7 && seg.size() > 0; k++) void'(seg.pop_back());
          destuff(seg, d);
          if (d.size() > 0) emit(d, d.size(), 1'b1, 1'b0);
        end
        synced = 1;
        seg.delete();
      end else if (synced) begin
        seg.push_back(b);
      end
    end
  endtask

  task automatic feed();
    logic [IN_W-1:0] v;
    int waited;
    bit ok;
    for (int w = 0; w < bits.size() / IN_W; w++) begin
      for (int j = 0; j < IN_W; j++) v[IN_W-1-j] = bits[w*IN_W+j];
      in_valid = 1'b1;
      in_data  = v;
      ok = 0;
      waited = 0;
      while (!ok && waited < 300) begin
        @(negedge clk);
        waited++;
        if (in_ready) begin
          ok = 1;
          @(posedge clk);
          #1;
        end
      end
      if (!ok) begin
        check("in_accept_timeout", int'(in_ready), 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_stall(input int n);
    int waited;
    waited = 0;
    while (!out_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic run_test(input string name, input int stall);
    int waited;
    while (bits.size() % IN_W != 0) bits.push_back(1'b1);
    model_run();
    check({name, "_model_len"}, expq.size(), pinq.size());
    foreach (pinq[i]) if (i < expq.size()) check({name, "_model_word"}, expq[i], pinq[i]);
    fork
      feed();
      begin
        if (stall > 0) do_stall(stall);
      end
    join
    waited = 0;
    while ((expq.size() != 0 || out_valid) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_drained"}, expq.size(), 0);
    repeat (24) @(negedge clk);
    @(posedge clk); #1;
    bits.delete();
  endtask

  // Scoreboard and hold checks, sampled on the falling edge.
  task automatic monitor();
    bit held;
    int prev, cur;
    held = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst) held = 0;
      else begin
        cur = dut_word() | (int'(out_valid) << 14);
        if (frame_active) fa_cnt++;
        if (in_valid && !in_ready) ir_cnt++;
        if (held) check("stall_hold", cur, prev);
        if (out_valid && out_ready) begin
          if (expq.size() == 0) check("unexpected_word", dut_word(), -1);
          else check("word", dut_word(), expq.pop_front());
        end
        held = out_valid && !out_ready;
        prev = cur;
      end
    end
  endtask

  initial begin
    int fa0, ir0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_nbits", int'(out_nbits), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_frame_active", int'(frame_active), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: idle, then 7E A5 7E
    fa0 = fa_cnt;
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_pay(8'hA5, 8); push_v(8'h7E, 8);
    pinq = '{32'h8A5, 32'h1000};
    run_test("T1", 0);
    check("T1_fa_seen", int'(fa_cnt > fa0), 1);
    check("T1_fa_after", int'(frame_active), 0);

    // T2: FF stuffed as 111110111
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_pay(8'hFF, 8); push_v(8'h7E, 8);
    pinq = '{32'h8FF, 32'h1000};
    run_test("T2", 0);

    // T3: 12-bit payload ABC
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_pay(12'hABC, 12); push_v(8'h7E, 8);
    pinq = '{32'h8AB, 32'h14C0};
    run_test("T3", 0);

    // T4: three flags, empty frames
    fa0 = fa_cnt;
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_v(8'h7E, 8); push_v(8'h7E, 8);
    pinq.delete();
    run_test("T4", 0);
    check("T4_fa_never", fa_cnt - fa0, 0);

    // T5: 4-byte frame with 40-cycle output stall
    ir0 = ir_cnt;
    push_v(16'hFFFF, 16); push_v(8'h7E, 8);
    push_pay(8'h12, 8); push_pay(8'h34, 8); push_pay(8'h56, 8); push_pay(8'h78, 8);
    push_v(8'h7E, 8); push_v(16'hFFFF, 16);
    pinq = '{32'h812, 32'h834, 32'h856, 32'h878, 32'h1000};
    run_test("T5", 40);
    check("T5_in_ready_dropped", int'(ir_cnt > ir0), 1);

    // T6: abort after 5 payload bits, then 7E 3C 7E
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_v(5'b10100, 5); push_v(7'h7F, 7);
    push_v(8'h7E, 8); push_pay(8'h3C, 8); push_v(8'h7E, 8);
`ifdef HDLC_ABORT_DETECT_EN
    pinq = '{32'h3000, 32'h83C, 32'h1000};
`else
    pinq = '{32'h83C, 32'h1000};
`endif
    run_test("T6", 0);
    check("T6_fa_after", int'(frame_active), 0);

    // T7: payload that needs stuffing in several places, including a data 7E
    push_v(16'hFFFF, 16); push_v(8'h7E, 8);
    push_pay(8'h7E, 8); push_pay(8'hFF, 8); push_pay(8'h00, 8);
    push_pay(8'hF8, 8); push_pay(8'h1F, 8); push_pay(8'hC3, 8);
    push_v(8'h7E, 8);
    pinq = '{32'h87E, 32'h8FF, 32'h800, 32'h8F8, 32'h81F, 32'h8C3, 32'h1000};
    run_test("T7", 0);

    // T8: 15-bit payload, final word carries OUT_W-1 bits
    push_v(16'hFFFF, 16); push_v(8'h7E, 8); push_pay(15'h6D5B, 15); push_v(8'h7E, 8);
    pinq = '{32'h8DA, 32'h17B6};
    run_test("T8", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
